// File: rtl/seq_mult.sv
// -----------------------------------------------------------------------------
// seq_mult -- sequential shift-and-add unsigned multiplier.
//
// Computes o = a * b one multiplier bit per clock. After the load edge the
// block spends WIDTH edges accumulating partial products, then writes the
// final sum to o on the edge that performs the last step.
//
// Ports:
//   clk  in   1        rising-edge clock
//   rst  in   1        synchronous, active-low reset
//   a    in   WIDTH    unsigned multiplicand (latched on the load edge)
//   b    in   WIDTH    unsigned multiplier   (latched on the load edge)
//   o    out  2*WIDTH  registered product; changes only on completion/reset
//
// Build option:
//   SEQ_MULT_AUTO_RESTART_EN -- when defined, the DONE state watches a/b and
//   starts a new multiplication whenever they differ from the latched
//   operands. When undefined, DONE is terminal until reset.
// -----------------------------------------------------------------------------
module seq_mult #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   o
);

  // Step counter only needs to address bits 0..WIDTH-1 of the multiplier.
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]          r_state;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [2*WIDTH-1:0]  r_acc;
  logic [IW-1:0]       r_cnt;

  logic                w_b_bit;
  logic [2*WIDTH-1:0]  w_a_ext;
  logic [2*WIDTH-1:0]  w_addend;
  logic [2*WIDTH-1:0]  w_sum;
  logic                w_last;

  // Partial product for the current step: A_reg shifted by the step index,
  // gated by the corresponding multiplier bit.
  assign w_b_bit  = r_b[r_cnt];
  assign w_a_ext  = {{WIDTH{1'b0}}, r_a};
  assign w_addend = w_b_bit ? (w_a_ext << r_cnt) : '0;
  assign w_sum    = r_acc + w_addend;
  assign w_last   = (r_cnt == IW'(WIDTH - 1));

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others; blocking '=' would
  // make the result depend on statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // Reset wins over every transition, including a pending completion,
      // so an aborted operation never leaks a partial sum into o.
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      o       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_a     <= a;
          r_b     <= b;
          r_acc   <= '0;
          r_cnt   <= '0;
          r_state <= S_CALC;
        end

        S_CALC: begin
          // No early exit on zero operands: latency is always WIDTH steps.
          r_acc <= w_sum;
          r_cnt <= r_cnt + IW'(1);
          if (w_last) begin
            o       <= w_sum;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
`ifdef SEQ_MULT_AUTO_RESTART_EN
          // o keeps the previous product until the new run completes.
          if ((a != r_a) || (b != r_b)) begin
            r_a     <= a;
            r_b     <= b;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= S_CALC;
          end
`else
          r_state <= S_DONE;
`endif
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// -----------------------------------------------------------------------------
// tb_seq_mult -- directed self-checking bench for seq_mult (WIDTH = 4).
//
// Inputs are driven 1 time unit after each rising edge and o is sampled at
// the same point, so every check observes the value registered on the edge
// just taken. Expected products are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_seq_mult;

  localparam int WIDTH = 4;

  logic               clk;
  logic               rst;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] o;

  int total;
  int bad;

  seq_mult #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .o   (o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [2*WIDTH-1:0] expected);
    total++;
    assert (o === expected)
    else begin
      bad++;
      $error("FAIL %s: o=%0d expected=%0d", tag, o, expected);
    end
  endtask

  // Reset for one edge, then run one multiplication with the 5-edge latency:
  // o must read 0 after edges 1..4 and the product after edge 5.
  task automatic run_mult(input string tag, input logic [WIDTH-1:0] va,
                          input logic [WIDTH-1:0] vb,
                          input logic [2*WIDTH-1:0] prod);
    rst = 1'b0;
    tick();
    check({tag, "_rst"}, 8'd0);
    rst = 1'b1;
    a   = va;
    b   = vb;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check({tag, "_busy"}, 8'd0);
    end
    tick();
    check({tag, "_done"}, prod);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    a     = '0;
    b     = '0;

    // Reset state, then 2*2 with the exact latency and a long hold.
    run_mult("m2x2", 4'd2, 4'd2, 8'd4);
    for (int i = 0; i < 100; i++) begin
      tick();
      check("hold4", 8'd4);
    end

    // Back-to-back operations separated by reset pulses.
    run_mult("m7x2",   4'd7,  4'd2,  8'd14);
    run_mult("m5x2",   4'd5,  4'd2,  8'd10);
    run_mult("m3x3",   4'd3,  4'd3,  8'd9);
    run_mult("m15x15", 4'd15, 4'd15, 8'd225);
    run_mult("m0x9",   4'd0,  4'd9,  8'd0);
    run_mult("m9x0",   4'd9,  4'd0,  8'd0);
    run_mult("m1x13",  4'd1,  4'd13, 8'd13);

    // Reset in the middle of 6*5: abort, then 4*3 must give 12, never 30.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    a   = 4'd6;
    b   = 4'd5;
    tick();                       // edge 1: load
    tick();                       // edge 2: step 0
    rst = 1'b0;
    tick();                       // edge 3: reset wins
    check("abort_rst", 8'd0);
    rst = 1'b1;
    a   = 4'd4;
    b   = 4'd3;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("abort_busy", 8'd0);
    end
    tick();
    check("abort_done", 8'd12);

    // Operand change during CALC is ignored: 6*5 still gives 30.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    a   = 4'd6;
    b   = 4'd5;
    tick();                       // edge 1: load
    a   = 4'd1;                   // seen from edge 2 onward
    for (int i = 2; i <= 4; i++) begin
      tick();
      check("latch_busy", 8'd0);
    end
    tick();
    check("latch_done", 8'd30);

    // New operands once DONE: restart build recomputes 2*5, default holds.
    a = 4'd2;
`ifdef SEQ_MULT_AUTO_RESTART_EN
    for (int i = 0; i < 4; i++) begin
      tick();
      check("restart_hold", 8'd30);
    end
    tick();
    check("restart_done", 8'd10);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("restart_keep", 8'd10);
    end
`else
    for (int i = 0; i < 10; i++) begin
      tick();
      check("done_terminal", 8'd30);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
